mem_access_unit: RTL and testbench
==================================

# mem_access_unit

MEM-stage access controller that consumes the EX/MEM pipeline register outputs, performs loads and stores against the data memory over a req/ack handshake, and produces the registered write-back bundle for MEM/WB. It stalls the front of the pipeline, including EX/MEM, while an access is outstanding. It also handles byte/half/word lane alignment, load sign extension and access timeout.

## Interface
- TIMEOUT, 255: maximum cycles `mem_req` is held without `mem_ack` before the access is aborted (1..255).
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `have_inst` in 1: EX/MEM slot holds a valid instruction.
- `dram_sel` in 2: 00 none, 01 load, 10 store, 11 treated as none.
- `addr_mode` in 2: 00 word, 01 half, 10 byte, 11 treated as word.
- `sext2_sel` in 1: 1 sign-extends a byte/half load, 0 zero-extends it.
- `alu_c` in 32: effective byte address.
- `rf_rD2` in 32: store data (LSBs significant).
- `wb_ena` / `wb_reg` / `wb_value` in 1/5/32: write-back bundle from EX.
- `mem_req` out 1: access request, level held until ack or timeout.
- `mem_we` out 1: 1 store, 0 load.
- `mem_addr` out 32: `{alu_c[31:2],2'b00}`.
- `mem_wstrb` out 4: byte-lane write enables (0000 on loads).
- `mem_wdata` out 32: lane-replicated store data.
- `mem_ack` in 1: one-cycle completion pulse; `mem_rdata` is valid in the same cycle.
- `mem_rdata` in 32: read word.
- `stall` out 1: combinational; freezes IF..EX/MEM while high.
- `valid_o` out 1: registered; MEM/WB bundle valid.
- `wb_ena_o` / `wb_reg_o` / `wb_value_o` out 1/5/32: registered MEM/WB bundle.
- `err_o` out 1: registered one-cycle pulse on a misaligned access or a timeout.

## Operation
- FSM states: IDLE, BUSY. A memory op is `have_inst & (dram_sel==01 | dram_sel==10)`.
- Alignment:
  - Half is misaligned when `alu_c[0]=1`.
  - Word is misaligned when `alu_c[1:0]!=0`.
  - Byte is never misaligned.
- IDLE, aligned memory op:
  - `stall=1`; next state BUSY; timeout counter cleared.
- IDLE, misaligned memory op:
  - No request and no stall.
  - Next cycle: `valid_o=1`, `wb_ena_o=0`, `err_o=1`.
- IDLE, other valid instruction:
  - Next cycle: `valid_o=1` and the `wb_*` inputs copied to `wb_*_o`.
- IDLE, `have_inst=0`: next cycle `valid_o=0`, `wb_ena_o=0`.
- BUSY:
  - `mem_req=1` with `mem_addr`, `mem_we`, `mem_wstrb` and `mem_wdata` derived combinationally from the held (stalled) inputs.
  - `stall = ~mem_ack`.
- BUSY with `mem_ack`:
  - Return to IDLE; result registered next cycle with `valid_o=1`.
  - Load: `wb_value_o` = extracted load data.
  - Store: `wb_value_o = wb_value`.
  - `wb_ena_o = wb_ena` in both cases.
- BUSY, counter reaches TIMEOUT without ack:
  - `mem_req` drops; return to IDLE with stall released.
  - Next cycle: `valid_o=1`, `wb_ena_o=0`, `err_o=1`.
- Store lanes:
  - Byte: `wstrb = 0001<<alu_c[1:0]`, `wdata = {4{rf_rD2[7:0]}}`.
  - Half: `wstrb = alu_c[1] ? 1100 : 0011`, `wdata = {2{rf_rD2[15:0]}}`.
  - Word: `wstrb = 1111`, `wdata = rf_rD2`.
- Load extraction:
  - Byte: `mem_rdata >> (8*alu_c[1:0])`, low 8 bits.
  - Half: `mem_rdata >> (16*alu_c[1])`, low 16 bits.
  - Extended to 32 bits by `sext2_sel`.
- Outside BUSY: `mem_req=0`, `mem_we=0`, `mem_wstrb=0000`, `mem_wdata=0`, `mem_addr=0`.

## Timing
- Non-memory instruction: 1-cycle latency, no stall.
- Memory op:
  - Cycle 0 (IDLE): detect, `stall=1`.
  - Cycle 1 onward: `mem_req=1`.
  - Ack in cycle k: stall released in cycle k (EX/MEM advances at the end of k).
  - `valid_o` in cycle k+1.
- Minimum stall is 1 cycle, when ack arrives in the first BUSY cycle.
- Timeout: `mem_req` is high for exactly TIMEOUT cycles; `stall` falls in the last of them.
- An ack arriving in the same cycle as the timeout wins: the access completes normally and no error is raised.
- `mem_ack` while not in BUSY is ignored.
- Reset (asserted anytime, including mid-access):
  - State → IDLE, counter 0.
  - Registered outputs return to 0; `mem_req`, `stall` and the other combinational outputs return to 0 through the IDLE state.
  - The aborted access produces no `valid_o`.
- Back-to-back memory ops: the second op is detected in cycle k+1 (IDLE) and its `stall=1` is asserted in that cycle.

## Test plan
- `lb`, `alu_c=0x1003`, `sext2_sel=1`, `mem_rdata=0x80FF_1234`, ack in 3rd BUSY cycle → `mem_addr=0x1000`; stall for 3 cycles; `wb_value_o=0xFFFF_FF80`, `valid_o=1` one cycle after ack.
- `sh`, `alu_c=0x2002`, `rf_rD2=0xDEAD_BEEF`, immediate ack → `mem_we=1`, `mem_wstrb=1100`, `mem_wdata=0xBEEF_BEEF`; single stall cycle.
- `lw`, `alu_c=0x3001` → no `mem_req`, no stall; next cycle `err_o=1`, `wb_ena_o=0`.
- Word load, never acked, TIMEOUT=4 → `mem_req` high for 4 cycles, then `err_o` pulse, stall released, `wb_ena_o=0`.
- Reset deasserted→asserted during BUSY → `mem_req` and `stall` drop; all outputs 0; no `valid_o` after reset release.
- ALU op, then lw, then ALU op back-to-back → `valid_o` sequence correct; the ALU result bypasses the memory path with 1-cycle latency; the lw stalls only its own slot.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM-stage load/store controller: drives a req/ack data-memory port, stalls the
// front of the pipeline while an access is outstanding, and registers the MEM/WB bundle.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        have_inst,
  input  logic [1:0]  dram_sel,
  input  logic [1:0]  addr_mode,
  input  logic        sext2_sel,
  input  logic [31:0] alu_c,
  input  logic [31:0] rf_rD2,
  input  logic        wb_ena,
  input  logic [4:0]  wb_reg,
  input  logic [31:0] wb_value,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic        valid_o,
  output logic        wb_ena_o,
  output logic [4:0]  wb_reg_o,
  output logic [31:0] wb_value_o,
  output logic        err_o
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  logic [0:0]  state_reg, state_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic        valid_reg, valid_next;
  logic        wb_ena_reg, wb_ena_next;
  logic [4:0]  wb_reg_reg, wb_reg_next;
  logic [31:0] wb_value_reg, wb_value_next;
  logic        err_reg, err_next;

  logic        is_load, is_store, mem_op, misaligned, busy, tmo_hit;
  logic [3:0]  wstrb_calc;
  logic [31:0] wdata_calc, load_data;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign is_load  = have_inst & (dram_sel == 2'b01);
  assign is_store = have_inst & (dram_sel == 2'b10);
  assign mem_op   = is_load | is_store;
  assign busy     = (state_reg == BUSY);
  // The last permitted BUSY cycle is the one where the counter sits at TIMEOUT-1.
  assign tmo_hit  = busy & (cnt_reg == TMO_LAST);

  always_comb begin
    case (addr_mode)
      2'b01:   misaligned = alu_c[0];
      2'b10:   misaligned = 1'b0;
      default: misaligned = |alu_c[1:0];
    endcase
  end

  always_comb begin
    wstrb_calc = 4'b1111;
    wdata_calc = rf_rD2;
    case (addr_mode)
      2'b10: begin
        wstrb_calc = 4'b0001 << alu_c[1:0];
        wdata_calc = {4{rf_rD2[7:0]}};
      end
      2'b01: begin
        wstrb_calc = alu_c[1] ? 4'b1100 : 4'b0011;
        wdata_calc = {2{rf_rD2[15:0]}};
      end
      default: ;
    endcase
  end

  assign byte_sel = 8'(mem_rdata >> {alu_c[1:0], 3'b000});
  assign half_sel = alu_c[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    case (addr_mode)
      2'b10:   load_data = {{24{sext2_sel & byte_sel[7]}}, byte_sel};
      2'b01:   load_data = {{16{sext2_sel & half_sel[15]}}, half_sel};
      default: load_data = mem_rdata;
    endcase
  end

  assign mem_req   = busy;
  assign mem_we    = busy & is_store;
  assign mem_addr  = busy ? {alu_c[31:2], 2'b00} : 32'h0;
  assign mem_wstrb = (busy & is_store) ? wstrb_calc : 4'b0000;
  assign mem_wdata = (busy & is_store) ? wdata_calc : 32'h0;
  // An ack in the timeout cycle completes the access, so ack is tested first.
  assign stall     = busy ? (~mem_ack & ~tmo_hit) : (mem_op & ~misaligned);

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    valid_next    = 1'b0;
    wb_ena_next   = 1'b0;
    wb_reg_next   = wb_reg;
    wb_value_next = wb_value;
    err_next      = 1'b0;
    if (!busy) begin
      if (mem_op && !misaligned) begin
        state_next = BUSY;
        cnt_next   = 8'd0;
      end else if (mem_op) begin
        valid_next = 1'b1;
        err_next   = 1'b1;
      end else if (have_inst) begin
        valid_next  = 1'b1;
        wb_ena_next = wb_ena;
      end
    end else if (mem_ack) begin
      state_next  = IDLE;
      valid_next  = 1'b1;
      wb_ena_next = wb_ena;
      if (is_load) wb_value_next = load_data;
    end else if (tmo_hit) begin
      state_next = IDLE;
      valid_next = 1'b1;
      err_next   = 1'b1;
    end else begin
      cnt_next = cnt_reg + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= 8'd0;
      valid_reg    <= 1'b0;
      wb_ena_reg   <= 1'b0;
      wb_reg_reg   <= 5'd0;
      wb_value_reg <= 32'h0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      valid_reg    <= valid_next;
      wb_ena_reg   <= wb_ena_next;
      wb_reg_reg   <= wb_reg_next;
      wb_value_reg <= wb_value_next;
      err_reg      <= err_next;
    end
  end

  assign valid_o    = valid_reg;
  assign wb_ena_o   = wb_ena_reg;
  assign wb_reg_o   = wb_reg_reg;
  assign wb_value_o = wb_value_reg;
  assign err_o      = err_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with TIMEOUT=4; each task owns one scenario.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        have_inst = 1'b0;
  logic [1:0]  dram_sel = 2'b00;
  logic [1:0]  addr_mode = 2'b00;
  logic        sext2_sel = 1'b0;
  logic [31:0] alu_c = 32'h0;
  logic [31:0] rf_rD2 = 32'h0;
  logic        wb_ena = 1'b0;
  logic [4:0]  wb_reg = 5'd0;
  logic [31:0] wb_value = 32'h0;
  logic        mem_req, mem_we, mem_ack = 1'b0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = 32'h0;
  logic [3:0]  mem_wstrb;
  logic        stall, valid_o, wb_ena_o, err_o;
  logic [4:0]  wb_reg_o;
  logic [31:0] wb_value_o;

  int errors = 0;
  int checks = 0;

  mem_access_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .have_inst(have_inst), .dram_sel(dram_sel),
    .addr_mode(addr_mode), .sext2_sel(sext2_sel), .alu_c(alu_c), .rf_rD2(rf_rD2),
    .wb_ena(wb_ena), .wb_reg(wb_reg), .wb_value(wb_value),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall(stall),
    .valid_o(valid_o), .wb_ena_o(wb_ena_o), .wb_reg_o(wb_reg_o),
    .wb_value_o(wb_value_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end else begin
      $display("ok   %s = %h", name, got);
    end
  endtask

  task automatic set_op(input logic [1:0] sel, input logic [1:0] mode, input logic sx,
                        input logic [31:0] a, input logic [31:0] d, input logic en,
                        input logic [4:0] r, input logic [31:0] v);
    have_inst = 1'b1; dram_sel = sel; addr_mode = mode; sext2_sel = sx;
    alu_c = a; rf_rD2 = d; wb_ena = en; wb_reg = r; wb_value = v;
  endtask

  task automatic test_reset();
    #1;
    chk("reset_mem_req", {31'b0, mem_req}, 32'd0);
    chk("reset_stall", {31'b0, stall}, 32'd0);
    chk("reset_valid", {31'b0, valid_o}, 32'd0);
    chk("reset_wb_value", wb_value_o, 32'h0);
    tick(); rst = 1'b1; tick();
    chk("post_reset_valid", {31'b0, valid_o}, 32'd0);
  endtask

  task automatic test_lb_sext();
    set_op(2'b01, 2'b10, 1'b1, 32'h0000_1003, 32'h0, 1'b1, 5'd5, 32'h0);
    #1;
    chk("lb_c0_stall", {31'b0, stall}, 32'd1);
    chk("lb_c0_req", {31'b0, mem_req}, 32'd0);
    tick();
    chk("lb_b1_req", {31'b0, mem_req}, 32'd1);
    chk("lb_b1_addr", mem_addr, 32'h0000_1000);
    chk("lb_b1_we", {31'b0, mem_we}, 32'd0);
    chk("lb_b1_wstrb", {28'b0, mem_wstrb}, 32'd0);
    chk("lb_b1_stall", {31'b0, stall}, 32'd1);
    chk("lb_b1_valid", {31'b0, valid_o}, 32'd0);
    tick();
    chk("lb_b2_stall", {31'b0, stall}, 32'd1);
    tick();
    mem_ack = 1'b1; mem_rdata = 32'h80FF_1234;
    #1;
    chk("lb_b3_stall", {31'b0, stall}, 32'd0);
    tick();
    mem_ack = 1'b0; have_inst = 1'b0;
    chk("lb_valid", {31'b0, valid_o}, 32'd1);
    chk("lb_wb_value", wb_value_o, 32'hFFFF_FF80);
    chk("lb_wb_ena", {31'b0, wb_ena_o}, 32'd1);
    chk("lb_wb_reg", {27'b0, wb_reg_o}, 32'd5);
    chk("lb_err", {31'b0, err_o}, 32'd0);
    chk("lb_req_dropped", {31'b0, mem_req}, 32'd0);
    tick();
    chk("lb_valid_clears", {31'b0, valid_o}, 32'd0);
  endtask

  task automatic test_sh_store();
    set_op(2'b10, 2'b01, 1'b0, 32'h0000_2002, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0000_0055);
    #1;
    chk("sh_c0_stall", {31'b0, stall}, 32'd1);
    tick();
    mem_ack = 1'b1;
    #1;
    chk("sh_req", {31'b0, mem_req}, 32'd1);
    chk("sh_we", {31'b0, mem_we}, 32'd1);
    chk("sh_addr", mem_addr, 32'h0000_2000);
    chk("sh_wstrb", {28'b0, mem_wstrb}, 32'h0000_000C);
    chk("sh_wdata", mem_wdata, 32'hBEEF_BEEF);
    chk("sh_stall", {31'b0, stall}, 32'd0);
    tick();
    mem_ack = 1'b0; have_inst = 1'b0;
    chk("sh_valid", {31'b0, valid_o}, 32'd1);
    chk("sh_wb_value", wb_value_o, 32'h0000_0055);
    chk("sh_wb_ena", {31'b0, wb_ena_o}, 32'd0);
  endtask

  task automatic test_lanes();
    set_op(2'b10, 2'b10, 1'b0, 32'h0000_7001, 32'h1234_56AB, 1'b0, 5'd0, 32'h0);
    tick();
    mem_ack = 1'b1;
    #1;
    chk("sb_wstrb", {28'b0, mem_wstrb}, 32'h0000_0002);
    chk("sb_wdata", mem_wdata, 32'hABAB_ABAB);
    tick();
    mem_ack = 1'b0;
    set_op(2'b01, 2'b01, 1'b0, 32'h0000_8002, 32'h0, 1'b1, 5'd2, 32'h0);
    tick();
    mem_ack = 1'b1; mem_rdata = 32'h9876_5432;
    #1;
    chk("lhu_addr", mem_addr, 32'h0000_8000);
    tick();
    mem_ack = 1'b0; have_inst = 1'b0;
    chk("lhu_wb_value", wb_value_o, 32'h0000_9876);
  endtask

  task automatic test_misaligned();
    set_op(2'b01, 2'b00, 1'b0, 32'h0000_3001, 32'h0, 1'b1, 5'd4, 32'h0);
    #1;
    chk("mis_req", {31'b0, mem_req}, 32'd0);
    chk("mis_stall", {31'b0, stall}, 32'd0);
    tick();
    have_inst = 1'b0;
    chk("mis_err", {31'b0, err_o}, 32'd1);
    chk("mis_valid", {31'b0, valid_o}, 32'd1);
    chk("mis_wb_ena", {31'b0, wb_ena_o}, 32'd0);
    tick();
    chk("mis_err_pulse", {31'b0, err_o}, 32'd0);
  endtask

  task automatic test_timeout();
    set_op(2'b01, 2'b00, 1'b0, 32'h0000_4000, 32'h0, 1'b1, 5'd6, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("tmo_req_%0d", i), {31'b0, mem_req}, 32'd1);
      chk($sformatf("tmo_stall_%0d", i), {31'b0, stall}, (i == 3) ? 32'd0 : 32'd1);
    end
    tick();
    have_inst = 1'b0;
    chk("tmo_req_low", {31'b0, mem_req}, 32'd0);
    chk("tmo_err", {31'b0, err_o}, 32'd1);
    chk("tmo_valid", {31'b0, valid_o}, 32'd1);
    chk("tmo_wb_ena", {31'b0, wb_ena_o}, 32'd0);
    tick();
    chk("tmo_err_pulse", {31'b0, err_o}, 32'd0);
  endtask

  task automatic test_ack_at_timeout();
    set_op(2'b01, 2'b00, 1'b0, 32'h0000_4100, 32'h0, 1'b1, 5'd8, 32'h0);
    tick(); tick(); tick(); tick();
    mem_ack = 1'b1; mem_rdata = 32'h1357_9BDF;
    #1;
    chk("ackt_stall", {31'b0, stall}, 32'd0);
    tick();
    mem_ack = 1'b0; have_inst = 1'b0;
    chk("ackt_err", {31'b0, err_o}, 32'd0);
    chk("ackt_wb_ena", {31'b0, wb_ena_o}, 32'd1);
    chk("ackt_wb_value", wb_value_o, 32'h1357_9BDF);
  endtask

  task automatic test_reset_mid_access();
    set_op(2'b10, 2'b00, 1'b0, 32'h0000_5000, 32'hAAAA_5555, 1'b1, 5'd1, 32'h0);
    tick();
    chk("rst_busy_req", {31'b0, mem_req}, 32'd1);
    #2;
    rst = 1'b0; have_inst = 1'b0;
    #1;
    chk("rst_req_drop", {31'b0, mem_req}, 32'd0);
    chk("rst_stall_drop", {31'b0, stall}, 32'd0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_wb_value", wb_value_o, 32'h0);
    chk("rst_wb_reg", {27'b0, wb_reg_o}, 32'd0);
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("rst_no_valid", {31'b0, valid_o}, 32'd0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("stray_ack_req", {31'b0, mem_req}, 32'd0);
    chk("stray_ack_valid", {31'b0, valid_o}, 32'd0);
  endtask

  task automatic test_back_to_back();
    set_op(2'b00, 2'b00, 1'b0, 32'h0, 32'h0, 1'b1, 5'd3, 32'h0000_0111);
    #1;
    chk("b2b_alu1_stall", {31'b0, stall}, 32'd0);
    tick();
    chk("b2b_alu1_valid", {31'b0, valid_o}, 32'd1);
    chk("b2b_alu1_value", wb_value_o, 32'h0000_0111);
    chk("b2b_alu1_reg", {27'b0, wb_reg_o}, 32'd3);
    set_op(2'b01, 2'b00, 1'b0, 32'h0000_6004, 32'h0, 1'b1, 5'd7, 32'h0);
    #1;
    chk("b2b_lw_stall", {31'b0, stall}, 32'd1);
    tick();
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    chk("b2b_lw_wait_valid", {31'b0, valid_o}, 32'd0);
    #1;
    chk("b2b_lw_release", {31'b0, stall}, 32'd0);
    tick();
    mem_ack = 1'b0;
    set_op(2'b00, 2'b00, 1'b0, 32'h0, 32'h0, 1'b1, 5'd9, 32'h0000_0222);
    chk("b2b_lw_valid", {31'b0, valid_o}, 32'd1);
    chk("b2b_lw_value", wb_value_o, 32'hCAFE_F00D);
    chk("b2b_lw_reg", {27'b0, wb_reg_o}, 32'd7);
    #1;
    chk("b2b_alu2_stall", {31'b0, stall}, 32'd0);
    tick();
    have_inst = 1'b0;
    chk("b2b_alu2_valid", {31'b0, valid_o}, 32'd1);
    chk("b2b_alu2_value", wb_value_o, 32'h0000_0222);
    chk("b2b_alu2_reg", {27'b0, wb_reg_o}, 32'd9);
    tick();
    chk("b2b_idle_valid", {31'b0, valid_o}, 32'd0);
  endtask

  initial begin
    test_reset();
    test_lb_sext();
    test_sh_store();
    test_lanes();
    test_misaligned();
    test_timeout();
    test_ack_at_timeout();
    test_reset_mid_access();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
